// File: rtl/game_pkg.sv
// Shared game types and limits.
// Used by the attack FSM (attack_state) and by the hit receiver
// (hit_state, damage and knockback ceilings).
package game_pkg;

  typedef enum logic [2:0] {
    NO_ATK   = 3'd0,
    NEUTRAL  = 3'd1,
    ATK_SIDE = 3'd2,
    ATK_UP   = 3'd3,
    ATK_DOWN = 3'd4
  } attack_state;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HITSTUN = 2'd1,
    INVULN  = 2'd2
  } hit_state;

  localparam int DAMAGE_MAX = 999;
  localparam int KB_MAX     = 63;

endpackage

// File: rtl/aabb_overlap.sv
// Combinational overlap test of two axis-aligned boxes.
// Each box is given as half-open intervals [lo, hi) on x and y, in signed
// coordinates so boxes may extend past the screen origin.
// Ports:
//   a_x_lo/a_x_hi/a_y_lo/a_y_hi : box A bounds
//   b_x_lo/b_x_hi/b_y_lo/b_y_hi : box B bounds
//   overlap                     : 1 when the boxes share at least one point
module aabb_overlap #(
  parameter int W = 12
) (
  input  logic signed [W-1:0] a_x_lo,
  input  logic signed [W-1:0] a_x_hi,
  input  logic signed [W-1:0] a_y_lo,
  input  logic signed [W-1:0] a_y_hi,
  input  logic signed [W-1:0] b_x_lo,
  input  logic signed [W-1:0] b_x_hi,
  input  logic signed [W-1:0] b_y_lo,
  input  logic signed [W-1:0] b_y_hi,
  output logic                overlap
);

  logic non_empty;

  // An empty interval on any axis can never overlap anything.
  assign non_empty = (a_x_lo < a_x_hi) && (a_y_lo < a_y_hi) &&
                     (b_x_lo < b_x_hi) && (b_y_lo < b_y_hi);

  assign overlap = non_empty &&
                   (a_x_lo < b_x_hi) && (b_x_lo < a_x_hi) &&
                   (a_y_lo < b_y_hi) && (b_y_lo < a_y_hi);

endmodule

// File: rtl/hit_receive_fsm.sv
// Per-player hit receiver: decides whether the opponent's active attack
// strikes this player, accumulates damage, latches knockback and runs the
// hitstun / invulnerability timers. All updates happen on frame_tick.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   frame_tick          : one-clk pulse per video frame
//   atk_active/atk_state: opponent attack flag and type
//   atk_x/atk_y         : opponent position
//   atk_facing_right    : opponent facing direction
//   self_x/self_y       : own position
//   clr_damage          : zero damage (KO / respawn)
//   hit_pulse           : one-clk pulse after an accepted hit
//   damage_pct          : accumulated damage 0..999
//   kb_vx/kb_vy         : knockback latched at the last hit
//   in_hitstun/invuln   : state decodes
//   rx_state            : current state
module hit_receive_fsm
  import game_pkg::*;
#(
  parameter int DMG_NEUTRAL   = 5,
  parameter int DMG_SIDE      = 8,
  parameter int DMG_UP        = 7,
  parameter int DMG_DOWN      = 6,
  parameter int KB_BASE       = 4,
  parameter int HITSTUN_MIN   = 8,
  parameter int INVULN_FRAMES = 30,
  parameter int HIT_OFS       = 16,
  parameter int HIT_W         = 24,
  parameter int HIT_H         = 16,
  parameter int HURT_W        = 16,
  parameter int HURT_H        = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_tick,
  input  logic              atk_active,
  input  attack_state       atk_state,
  input  logic [9:0]        atk_x,
  input  logic [9:0]        atk_y,
  input  logic              atk_facing_right,
  input  logic [9:0]        self_x,
  input  logic [9:0]        self_y,
  input  logic              clr_damage,
  output logic              hit_pulse,
  output logic [9:0]        damage_pct,
  output logic signed [7:0] kb_vx,
  output logic signed [7:0] kb_vy,
  output logic              in_hitstun,
  output logic              invuln,
  output hit_state          rx_state
);

  localparam logic signed [11:0] HIT_OFS_S = 12'(HIT_OFS);
  localparam logic signed [11:0] HIT_W_S   = 12'(HIT_W);
  localparam logic signed [11:0] HIT_H_S   = 12'(HIT_H);
  localparam logic signed [11:0] HURT_W_S  = 12'(HURT_W);
  localparam logic signed [11:0] HURT_H_S  = 12'(HURT_H);

  function automatic logic [9:0] sat_damage(input logic [10:0] sum);
    return (sum > 11'(DAMAGE_MAX)) ? 10'(DAMAGE_MAX) : sum[9:0];
  endfunction

  function automatic logic [5:0] sat_kb(input logic [7:0] raw);
    return (raw > 8'(KB_MAX)) ? 6'(KB_MAX) : raw[5:0];
  endfunction

  logic [7:0] timer;
  logic       armed;
  logic       prev_active;

  logic signed [11:0] ax, ay, sx, sy;
  logic signed [11:0] hit_x_lo, hit_x_hi, hit_y_lo, hit_y_hi;
  logic signed [11:0] hurt_x_lo, hurt_x_hi, hurt_y_lo, hurt_y_hi;
  logic               overlap;

  assign ax = {2'b00, atk_x};
  assign ay = {2'b00, atk_y};
  assign sx = {2'b00, self_x};
  assign sy = {2'b00, self_y};

  always_comb begin
    if (atk_facing_right) begin
      hit_x_lo = ax + HIT_OFS_S;
      hit_x_hi = ax + HIT_OFS_S + HIT_W_S;
    end else begin
      hit_x_lo = ax - HIT_OFS_S - HIT_W_S;
      hit_x_hi = ax - HIT_OFS_S;
    end
    hit_y_lo  = ay;
    hit_y_hi  = ay + HIT_H_S;
    hurt_x_lo = sx;
    hurt_x_hi = sx + HURT_W_S;
    hurt_y_lo = sy;
    hurt_y_hi = sy + HURT_H_S;
  end

  aabb_overlap #(.W(12)) u_overlap (
    .a_x_lo (hit_x_lo),
    .a_x_hi (hit_x_hi),
    .a_y_lo (hit_y_lo),
    .a_y_hi (hit_y_hi),
    .b_x_lo (hurt_x_lo),
    .b_x_hi (hurt_x_hi),
    .b_y_lo (hurt_y_lo),
    .b_y_hi (hurt_y_hi),
    .overlap(overlap)
  );

  logic [10:0]       dmg_add;
  logic [10:0]       dmg_base;
  logic [9:0]        dmg_new;
  logic [5:0]        kb_mag;
  logic signed [7:0] kb_full, kb_half;
  logic signed [7:0] vx_new, vy_new;
  logic [7:0]        hitstun_load;
  logic              accept;

  always_comb begin
    dmg_add = 11'd0;
    vx_new  = 8'sd0;
    vy_new  = 8'sd0;
    case (atk_state)
      NEUTRAL:  dmg_add = 11'(DMG_NEUTRAL);
      ATK_SIDE: dmg_add = 11'(DMG_SIDE);
      ATK_UP:   dmg_add = 11'(DMG_UP);
      ATK_DOWN: dmg_add = 11'(DMG_DOWN);
      default:  dmg_add = 11'd0;
    endcase

    // A clear on the same tick as a hit means the hit starts from zero.
    dmg_base     = clr_damage ? 11'd0 : {1'b0, damage_pct};
    dmg_new      = sat_damage(dmg_base + dmg_add);
    kb_mag       = sat_kb(8'(KB_BASE) + {1'b0, dmg_new[9:3]});
    kb_full      = {2'b00, kb_mag};
    kb_half      = {3'b000, kb_mag[5:1]};
    hitstun_load = 8'(HITSTUN_MIN) + {4'b0000, kb_mag[5:2]};

    case (atk_state)
      NEUTRAL, ATK_SIDE: begin
        vx_new = atk_facing_right ? kb_full : -kb_full;
        vy_new = -kb_full;
      end
      ATK_UP: begin
        vx_new = 8'sd0;
        vy_new = -kb_full;
      end
      ATK_DOWN: begin
        vx_new = atk_facing_right ? kb_half : -kb_half;
        vy_new = kb_half;
      end
      default: begin
        vx_new = 8'sd0;
        vy_new = 8'sd0;
      end
    endcase

    accept = (rx_state == IDLE) && armed && atk_active &&
             (atk_state != NO_ATK) && overlap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state    <= IDLE;
      damage_pct  <= 10'd0;
      kb_vx       <= 8'sd0;
      kb_vy       <= 8'sd0;
      timer       <= 8'd0;
      armed       <= 1'b0;
      prev_active <= 1'b0;
      hit_pulse   <= 1'b0;
    end else begin
      hit_pulse <= 1'b0;
      if (frame_tick) begin
        prev_active <= atk_active;
        if (accept) begin
          hit_pulse  <= 1'b1;
          damage_pct <= dmg_new;
          kb_vx      <= vx_new;
          kb_vy      <= vy_new;
          timer      <= hitstun_load;
          rx_state   <= HITSTUN;
          armed      <= 1'b0;
        end else begin
          if (clr_damage) damage_pct <= 10'd0;
          // Only arm while vulnerable, so an activation that starts
          // during hitstun/invuln can never land afterwards.
          if (!atk_active || rx_state != IDLE) armed <= 1'b0;
          else if (!prev_active)               armed <= 1'b1;
          case (rx_state)
            HITSTUN: begin
              if (timer == 8'd1) begin
                rx_state <= INVULN;
                timer    <= 8'(INVULN_FRAMES);
              end else begin
                timer <= timer - 8'd1;
              end
            end
            INVULN: begin
              if (timer == 8'd1) begin
                rx_state <= IDLE;
                timer    <= 8'd0;
              end else begin
                timer <= timer - 8'd1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign in_hitstun = (rx_state == HITSTUN);
  assign invuln     = (rx_state == INVULN);

endmodule

// File: tb/tb_hit_receive_fsm.sv
// Directed bench for hit_receive_fsm.
module tb_hit_receive_fsm;
  import game_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              frame_tick;
  logic              atk_active;
  attack_state       atk_state;
  logic [9:0]        atk_x, atk_y;
  logic              atk_facing_right;
  logic [9:0]        self_x, self_y;
  logic              clr_damage;
  logic              hit_pulse;
  logic [9:0]        damage_pct;
  logic signed [7:0] kb_vx, kb_vy;
  logic              in_hitstun, invuln;
  hit_state          rx_state;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hit_receive_fsm dut (
    .clk             (clk),
    .rst             (rst),
    .frame_tick      (frame_tick),
    .atk_active      (atk_active),
    .atk_state       (atk_state),
    .atk_x           (atk_x),
    .atk_y           (atk_y),
    .atk_facing_right(atk_facing_right),
    .self_x          (self_x),
    .self_y          (self_y),
    .clr_damage      (clr_damage),
    .hit_pulse       (hit_pulse),
    .damage_pct      (damage_pct),
    .kb_vx           (kb_vx),
    .kb_vy           (kb_vy),
    .in_hitstun      (in_hitstun),
    .invuln          (invuln),
    .rx_state        (rx_state)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One frame tick; returns at the falling edge right after the tick edge,
  // where the updated outputs and hit_pulse are visible.
  task automatic tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  // Fresh activation: low tick, rising (arming) tick, accepting tick.
  task automatic do_attack();
    atk_active = 1'b0;
    tick();
    atk_active = 1'b1;
    tick();
    tick();
  endtask

  // Drop the attack and count ticks spent in hitstun and invuln.
  task automatic run_to_idle(output int hs, output int iv);
    hs = 0;
    iv = 0;
    atk_active = 1'b0;
    while (in_hitstun && hs < 200) begin tick(); hs++; end
    while (invuln && iv < 200) begin tick(); iv++; end
  endtask

  int hs, iv, pulses;

  initial begin
    rst = 1'b1; frame_tick = 1'b0; atk_active = 1'b0; atk_state = NO_ATK;
    atk_x = 10'd100; atk_y = 10'd200; atk_facing_right = 1'b1;
    self_x = 10'd120; self_y = 10'd200; clr_damage = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("reset_state", 32'(rx_state), 32'(IDLE));
    check("reset_damage", 32'(damage_pct), 0);
    check("reset_kb_vx", 32'(kb_vx), 0);
    check("reset_pulse", 32'(hit_pulse), 0);

    // Basic hit.
    atk_state = NEUTRAL;
    atk_active = 1'b0;
    tick();
    atk_active = 1'b1;
    tick();
    check("arm_tick_no_pulse", 32'(hit_pulse), 0);
    tick();
    check("basic_pulse", 32'(hit_pulse), 1);
    check("basic_damage", 32'(damage_pct), 5);
    check("basic_kb_vx", 32'(kb_vx), 4);
    check("basic_kb_vy", 32'(kb_vy), -4);
    check("basic_in_hitstun", 32'(in_hitstun), 1);
    @(negedge clk);
    check("pulse_one_cycle", 32'(hit_pulse), 0);

    // Attack held through hitstun; re-activation during invuln.
    pulses = 0; hs = 0; iv = 0;
    while (in_hitstun && hs < 200) begin tick(); hs++; pulses += hit_pulse; end
    check("hitstun_ticks", hs, 9);
    while (invuln && iv < 200) begin
      atk_active = (iv == 0) ? 1'b0 : 1'b1;
      tick(); iv++; pulses += hit_pulse;
    end
    check("invuln_ticks", iv, 30);
    repeat (4) begin tick(); pulses += hit_pulse; end
    check("held_no_extra_pulse", pulses, 0);
    check("held_damage", 32'(damage_pct), 5);
    check("back_idle", 32'(rx_state), 32'(IDLE));

    // New activation in IDLE lands again.
    do_attack();
    check("second_pulse", 32'(hit_pulse), 1);
    check("second_damage", 32'(damage_pct), 10);
    check("second_kb_vx", 32'(kb_vx), 5);

    // Reset mid-hitstun.
    atk_active = 1'b0;
    tick(); tick();
    check("mid_hitstun", 32'(rx_state), 32'(HITSTUN));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_state", 32'(rx_state), 32'(IDLE));
    check("rst_damage", 32'(damage_pct), 0);
    check("rst_pulse", 32'(hit_pulse), 0);
    check("rst_kb_vy", 32'(kb_vy), 0);

    // Build damage to 997: 124 side hits then one neutral.
    atk_state = ATK_SIDE;
    for (int k = 0; k < 124; k++) begin
      do_attack();
      run_to_idle(hs, iv);
    end
    atk_state = NEUTRAL;
    do_attack();
    run_to_idle(hs, iv);
    check("build_damage", 32'(damage_pct), 997);

    // Saturating side hit from an attacker facing left: hitbox [120,144).
    atk_state = ATK_SIDE; atk_facing_right = 1'b0; atk_x = 10'd160;
    do_attack();
    check("sat_pulse", 32'(hit_pulse), 1);
    check("sat_damage", 32'(damage_pct), 999);
    check("sat_kb_vx", 32'(kb_vx), -63);
    check("sat_kb_vy", 32'(kb_vy), -63);
    run_to_idle(hs, iv);
    check("sat_hitstun_ticks", hs, 23);
    check("sat_invuln_ticks", iv, 30);

    // Left screen edge: hitbox [-30,-6) misses, [0,24) hits.
    atk_state = NEUTRAL; atk_x = 10'd10; self_x = 10'd0;
    do_attack();
    check("edge_miss_pulse", 32'(hit_pulse), 0);
    check("edge_miss_state", 32'(rx_state), 32'(IDLE));
    atk_x = 10'd40;
    do_attack();
    check("edge_hit_pulse", 32'(hit_pulse), 1);
    check("edge_hit_kb_vx", 32'(kb_vx), -63);
    run_to_idle(hs, iv);

    // Clear coinciding with an accepted neutral hit.
    atk_active = 1'b0;
    tick();
    atk_active = 1'b1;
    tick();
    clr_damage = 1'b1;
    tick();
    clr_damage = 1'b0;
    check("clr_hit_pulse", 32'(hit_pulse), 1);
    check("clr_hit_damage", 32'(damage_pct), 5);
    run_to_idle(hs, iv);

    // Clear alone.
    clr_damage = 1'b1;
    tick();
    clr_damage = 1'b0;
    check("clr_only_damage", 32'(damage_pct), 0);
    check("clr_only_state", 32'(rx_state), 32'(IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hit_receive_fsm.md
Name: hit_receive_fsm

Overview:
- Receiving end of the attack interface: takes the opponent's attack outputs (active flag, attack type, position) and decides whether this player is struck.
- On a hit it accumulates damage percent, computes knockback velocity and runs hitstun and invulnerability timers.
- Sits per player between the opponent's attack FSM and this player's movement/physics FSM, which consumes the knockback and hitstun outputs.
- Updates only on frame_tick.

Parameters:
- DMG_NEUTRAL, 5, damage added by a NEUTRAL hit
- DMG_SIDE, 8, damage for ATK_SIDE
- DMG_UP, 7, damage for ATK_UP
- DMG_DOWN, 6, damage for ATK_DOWN
- KB_BASE, 4, base knockback magnitude
- HITSTUN_MIN, 8, minimum hitstun frames
- INVULN_FRAMES, 30, post-hitstun invulnerable frames
- HIT_OFS, 16, hitbox offset in front of attacker
- HIT_W, 24, hitbox width
- HIT_H, 16, hitbox height
- HURT_W, 16, hurtbox width
- HURT_H, 24, hurtbox height

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- frame_tick  in  1  one-clk pulse per video frame
- atk_active  in  1  opponent attack active
- atk_state  in  attack_state  opponent attack type
- atk_x, atk_y  in  10 each  opponent position
- atk_facing_right  in  1  opponent facing direction
- self_x, self_y  in  10 each  own position
- clr_damage  in  1  KO/respawn: zero damage
- hit_pulse  out  1  one-clk pulse on accepted hit
- damage_pct  out  10  accumulated damage, 0..999
- kb_vx, kb_vy  out  8 signed each  knockback velocity latched at the last hit
- in_hitstun  out  1  state==HITSTUN
- invuln  out  1  state==INVULN
- rx_state  out  hit_state  current state

Behaviour:
- Reset (sync, highest priority, any state): state IDLE, damage_pct 0, kb_vx/kb_vy 0, timer 0, armed 0, hit_pulse 0.
- All state, timer and damage updates happen only on clk edges where frame_tick=1.
- hit_pulse is asserted exactly the clk cycle after the accepting tick and is 0 otherwise.
- Arming: armed is set on a tick where atk_active rises (prev 0 → now 1), and cleared on a tick where atk_active=0 or a hit is accepted. Result: at most one hit per attack activation, however long it is held.
- Hitbox, facing right: x in [atk_x+HIT_OFS, atk_x+HIT_OFS+HIT_W).
- Hitbox, facing left: x in [atk_x-HIT_OFS-HIT_W, atk_x-HIT_OFS).
- Hitbox y range: [atk_y, atk_y+HIT_H).
- Hurtbox: [self_x, self_x+HURT_W) × [self_y, self_y+HURT_H).
- Box arithmetic is 12-bit signed: no wrap, negative bounds allowed, and an empty interval never overlaps. Overlap is strict half-open on both axes.
- A hit is accepted on a tick when: state==IDLE && armed && atk_active && atk_state!=NO_ATK && overlap.
- dmg_new = min(damage_pct + DMG_type, 999).
- kb = min(KB_BASE + (dmg_new>>3), 63). s = atk_facing_right ? +1 : -1.
- NEUTRAL/SIDE: vx = s·kb, vy = −kb.
- UP: vx = 0, vy = −kb.
- DOWN: vx = s·(kb>>1), vy = +(kb>>1).
- FSM IDLE→HITSTUN on an accepted hit: timer = HITSTUN_MIN + (kb>>2).
- FSM HITSTUN: timer decrements each tick; on a tick with timer==1 → INVULN, timer = INVULN_FRAMES.
- FSM INVULN: decrements likewise; on a tick with timer==1 → IDLE.
- Attacks during HITSTUN/INVULN are ignored, and an attack armed during those states is not re-accepted later.
- kb_vx/kb_vy hold their values until the next accepted hit.
- clr_damage on a tick zeroes damage_pct. If a hit is accepted on the same tick, damage = DMG_type, computed from 0. State is unaffected.

Decomposition:
- Shared package game_pkg: attack_state enum {NO_ATK, NEUTRAL, ATK_SIDE, ATK_UP, ATK_DOWN}, hit_state enum {IDLE, HITSTUN, INVULN}, DAMAGE_MAX=999, KB_MAX=63. The attack FSM imports attack_state from the same package.
- One sub-module, aabb_overlap: combinational signed box-overlap test, reusable for the other player's hurtbox.

Test Plan:
- Basic hit: atk_x=100, atk_y=200, facing right, NEUTRAL, active rising; self_x=120, self_y=200 → one hit_pulse; damage 5; kb_vx=+4, kb_vy=−4; in_hitstun for 9 ticks, then invuln for 30 ticks, then IDLE.
- Hold: atk_active held 20 ticks with overlap → exactly one hit_pulse; damage stays 5.
- Invulnerability window: a second activation during INVULN → ignored. The same activation after returning to IDLE → damage 10, one pulse.
- Saturation: damage at 997, ATK_SIDE hit, attacker facing left → damage 999; kb=63; kb_vx=−63; kb_vy=−63; hitstun 23 ticks.
- Left edge: atk_x=10 facing left (hitbox x [−30,−6)), self_x=0 → no hit. Same with atk_x=40 (hitbox x [0,24)) → hit.
- Reset and clear: rst mid-HITSTUN → next cycle IDLE, damage 0, no pulse. clr_damage coinciding with an accepted NEUTRAL hit → damage 5.
